// File: rtl/fnv1a_hash_ctrl.sv
// FNV-1a 32-bit hash controller with a serial shift-add multiplier.
// Takes FEED/INIT/SNAPSHOT byte commands and exposes a latched digest.
module fnv1a_hash_ctrl #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter logic [31:0] PRIME        = 32'h01000193
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        busy,
    output logic [31:0] digest,
    output logic        digest_valid,
    input  logic [1:0]  rd_sel,
    output logic [7:0]  rd_byte,
    output logic [15:0] byte_count,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_FEED = 2'b00;
    localparam logic [1:0] OP_INIT = 2'b01;
    localparam logic [1:0] OP_SNAP = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] hash_q, hash_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] pbits_q, pbits_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [31:0] digest_q, digest_d;
    logic        dvalid_q, dvalid_d;
    logic        err_q, err_d;

    logic        cmd_fire;
    logic [31:0] acc_sum;

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q == MUL);
    assign cmd_fire     = cmd_valid & cmd_ready;
    assign acc_sum      = pbits_q[0] ? (acc_q + mcand_q) : acc_q;
    assign digest       = digest_q;
    assign digest_valid = dvalid_q;
    assign byte_count   = bcnt_q;
    assign err          = err_q;

    // Digest byte mux for the I2C read path, MSB first.
    always_comb begin
        rd_byte = digest_q[31:24];
        unique case (rd_sel)
            2'd0:    rd_byte = digest_q[31:24];
            2'd1:    rd_byte = digest_q[23:16];
            2'd2:    rd_byte = digest_q[15:8];
            default: rd_byte = digest_q[7:0];
        endcase
    end

    // Command decode and one multiply step per cycle while in MUL.
    always_comb begin
        state_d  = state_q;
        hash_d   = hash_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        pbits_d  = pbits_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    unique case (cmd_op)
                        OP_FEED: begin
                            mcand_d  = hash_q ^ {24'b0, cmd_data};
                            acc_d    = 32'b0;
                            pbits_d  = PRIME;
                            cnt_d    = 5'd0;
                            if (bcnt_q != 16'hFFFF) begin
                                bcnt_d = bcnt_q + 16'd1;
                            end
                            dvalid_d = 1'b0;
                            state_d  = MUL;
                        end
                        OP_INIT: begin
                            hash_d   = OFFSET_BASIS;
                            bcnt_d   = 16'd0;
                            err_d    = 1'b0;
                            dvalid_d = 1'b0;
                        end
                        OP_SNAP: begin
                            digest_d = hash_q;
                            dvalid_d = 1'b1;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                mcand_d = {mcand_q[30:0], 1'b0};
                pbits_d = {1'b0, pbits_q[31:1]};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hash_d  = acc_sum;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hash_q   <= OFFSET_BASIS;
            mcand_q  <= 32'b0;
            acc_q    <= 32'b0;
            pbits_q  <= 32'b0;
            cnt_q    <= 5'd0;
            bcnt_q   <= 16'd0;
            digest_q <= 32'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hash_q   <= hash_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            pbits_q  <= pbits_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_fnv1a_hash_ctrl.sv
// Directed testbench for fnv1a_hash_ctrl.
// Hand-computed FNV-1a vectors, handshake timing and saturation.
module tb_fnv1a_hash_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        busy;
    logic [31:0] digest;
    logic        digest_valid;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_byte;
    logic [15:0] byte_count;
    logic        err;

    int nvec;
    int nerr;
    int cyc;
    int acc_cyc;
    int prev_cyc;
    int low_cnt;

    fnv1a_hash_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid),
        .rd_sel       (rd_sel),
        .rd_byte      (rd_byte),
        .byte_count   (byte_count),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge, wait for acceptance (bounded).
    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input bit hold);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Count negedges with cmd_ready low until it rises (bounded).
    task automatic wait_idle(output int lows);
        lows = 0;
        while (!cmd_ready && lows < 100) begin
            @(negedge clk);
            lows++;
        end
        if (lows >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        rd_sel    = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_digest", digest, 32'h0);
        chk("rst_dvalid", {31'b0, digest_valid}, 32'd0);
        chk("rst_bcnt", {16'b0, byte_count}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(2'b10, 8'h00, 1'b0);
        chk("snap0_digest", digest, 32'h811C9DC5);
        chk("snap0_dvalid", {31'b0, digest_valid}, 32'd1);
        chk("snap0_bcnt", {16'b0, byte_count}, 32'd0);
        chk("rd0", {24'b0, rd_byte}, 32'h81);
        rd_sel = 2'd1; #1;
        chk("rd1", {24'b0, rd_byte}, 32'h1C);
        rd_sel = 2'd2; #1;
        chk("rd2", {24'b0, rd_byte}, 32'h9D);
        rd_sel = 2'd3; #1;
        chk("rd3", {24'b0, rd_byte}, 32'hC5);

        send(2'b00, 8'h61, 1'b0);
        chk("a_busy", {31'b0, busy}, 32'd1);
        chk("a_dvalid", {31'b0, digest_valid}, 32'd0);
        chk("a_bcnt", {16'b0, byte_count}, 32'd1);
        chk("a_rd_mul", {24'b0, rd_byte}, 32'hC5);
        wait_idle(low_cnt);
        chk("a_ready_low", low_cnt, 32'd32);
        chk("a_busy_end", {31'b0, busy}, 32'd0);
        send(2'b10, 8'h00, 1'b0);
        chk("a_digest", digest, 32'hE40C292C);
        chk("a_rd3", {24'b0, rd_byte}, 32'h2C);

        send(2'b01, 8'h00, 1'b0);
        chk("init_bcnt", {16'b0, byte_count}, 32'd0);
        send(2'b00, 8'h66, 1'b1);
        prev_cyc = acc_cyc;
        send(2'b00, 8'h6F, 1'b1);
        chk("fb_gap1", acc_cyc - prev_cyc, 32'd33);
        prev_cyc = acc_cyc;
        send(2'b00, 8'h6F, 1'b1);
        chk("fb_gap2", acc_cyc - prev_cyc, 32'd33);
        prev_cyc = acc_cyc;
        send(2'b00, 8'h62, 1'b1);
        chk("fb_gap3", acc_cyc - prev_cyc, 32'd33);
        prev_cyc = acc_cyc;
        send(2'b00, 8'h61, 1'b1);
        chk("fb_gap4", acc_cyc - prev_cyc, 32'd33);
        prev_cyc = acc_cyc;
        send(2'b00, 8'h72, 1'b0);
        chk("fb_gap5", acc_cyc - prev_cyc, 32'd33);
        wait_idle(low_cnt);
        send(2'b10, 8'h00, 1'b0);
        chk("fb_digest", digest, 32'hBF9CF968);
        chk("fb_bcnt", {16'b0, byte_count}, 32'd6);

        send(2'b01, 8'h00, 1'b0);
        send(2'b00, 8'h61, 1'b0);
        wait_idle(low_cnt);
        send(2'b01, 8'h00, 1'b0);
        send(2'b10, 8'h00, 1'b0);
        chk("ini_digest", digest, 32'h811C9DC5);
        chk("ini_bcnt", {16'b0, byte_count}, 32'd0);
        send(2'b11, 8'h00, 1'b0);
        chk("op3_err", {31'b0, err}, 32'd1);
        chk("op3_dvalid", {31'b0, digest_valid}, 32'd1);
        chk("op3_ready", {31'b0, cmd_ready}, 32'd1);
        send(2'b10, 8'h00, 1'b0);
        chk("op3_hash", digest, 32'h811C9DC5);
        send(2'b01, 8'h00, 1'b0);
        chk("init_err", {31'b0, err}, 32'd0);
        chk("init_dvalid", {31'b0, digest_valid}, 32'd0);

        send(2'b11, 8'h00, 1'b0);
        send(2'b10, 8'h00, 1'b0);
        send(2'b00, 8'h61, 1'b0);
        repeat (9) @(negedge clk);
        chk("rm_busy_pre", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_busy", {31'b0, busy}, 32'd0);
        chk("rm_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rm_digest", digest, 32'h0);
        chk("rm_dvalid", {31'b0, digest_valid}, 32'd0);
        chk("rm_bcnt", {16'b0, byte_count}, 32'd0);
        chk("rm_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'b10, 8'h00, 1'b0);
        chk("rm_snap", digest, 32'h811C9DC5);
        chk("rm_snap_bcnt", {16'b0, byte_count}, 32'd0);

        force dut.bcnt_q = 16'hFFFE;
        #1 release dut.bcnt_q;
        chk("sat_forced", {16'b0, byte_count}, 32'h0000FFFE);
        send(2'b00, 8'h01, 1'b0);
        chk("sat_dv1", {31'b0, digest_valid}, 32'd0);
        chk("sat_b1", {16'b0, byte_count}, 32'h0000FFFF);
        wait_idle(low_cnt);
        send(2'b10, 8'h00, 1'b0);
        chk("sat_up1", {31'b0, digest_valid}, 32'd1);
        send(2'b00, 8'h02, 1'b0);
        chk("sat_dv2", {31'b0, digest_valid}, 32'd0);
        chk("sat_b2", {16'b0, byte_count}, 32'h0000FFFF);
        wait_idle(low_cnt);
        send(2'b10, 8'h00, 1'b0);
        chk("sat_up2", {31'b0, digest_valid}, 32'd1);
        send(2'b00, 8'h03, 1'b0);
        chk("sat_dv3", {31'b0, digest_valid}, 32'd0);
        chk("sat_b3", {16'b0, byte_count}, 32'h0000FFFF);
        wait_idle(low_cnt);
        send(2'b10, 8'h00, 1'b0);
        chk("sat_up3", {31'b0, digest_valid}, 32'd1);
        chk("sat_final", {16'b0, byte_count}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
